// File: rtl/management_mdio_arbiter.sv
// ---------------------------------------------------------------------------
// management_mdio_arbiter
//
// Shares the single management-port MDIO transceiver among NUM_REQ
// requesters (QSPI register interface, PHY link poller, boot-time PHY init).
// Round-robin grant, one MDIO transaction at a time. The transceiver command
// bus is held stable for the whole transaction and read data is routed back
// to the winning requester.
//
// Optional feature: define MDIO_ARB_TIMEOUT_EN to enable a transaction
// timeout. A timed-out transaction completes with resp_err=1 and
// resp_rdata=16'hFFFF, TIMEOUT_CYCLES cycles after the strobe. Without the
// macro the arbiter waits indefinitely and resp_err is tied 0.
//
// Parameters
//   NUM_REQ         number of requesters, 1..8
//   TIMEOUT_CYCLES  strobe-to-abort cycles (timeout build only), 2..65535
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   req_valid[i]        request pending, held until req_ack[i]
//   req_wr[i]           1=write, 0=read
//   req_md_addr         PHY address per requester, slice [5i+:5]
//   req_reg_addr        register address per requester, slice [5i+:5]
//   req_wdata           write data per requester, slice [16i+:16]
//   req_ack[i]          1-cycle pulse, request latched
//   resp_valid[i]       1-cycle pulse, transaction complete
//   resp_rdata          read data (0 for writes), held between responses
//   resp_err            timeout flag, held between responses
//   arb_busy            high whenever the arbiter is not idle
//   phy_md_addr/phy_reg_addr/phy_wr_data   registered command bus
//   phy_reg_wr/phy_reg_rd                  1-cycle command strobes
//   phy_rd_data         read data from transceiver, valid when busy falls
//   mgmt_busy_fwd       transceiver busy
// ---------------------------------------------------------------------------
module management_mdio_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_wr,
    input  logic [5*NUM_REQ-1:0]    req_md_addr,
    input  logic [5*NUM_REQ-1:0]    req_reg_addr,
    input  logic [16*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [15:0]             resp_rdata,
    output logic                    resp_err,
    output logic                    arb_busy,
    output logic [4:0]              phy_md_addr,
    output logic [4:0]              phy_reg_addr,
    output logic [15:0]             phy_wr_data,
    output logic                    phy_reg_wr,
    output logic                    phy_reg_rd,
    input  logic [15:0]             phy_rd_data,
    input  logic                    mgmt_busy_fwd
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
        $error("management_mdio_arbiter: NUM_REQ must be 1..8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("management_mdio_arbiter: TIMEOUT_CYCLES must be 2..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_win;
    logic                 r_wr;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   r_resp_valid;
    logic [15:0]          r_rdata;
    logic [4:0]           r_md_addr;
    logic [4:0]           r_reg_addr;
    logic [15:0]          r_wdata;
    logic                 r_reg_wr;
    logic                 r_reg_rd;

    logic                 w_found;
    logic [PTR_W-1:0]     w_win;

`ifdef MDIO_ARB_TIMEOUT_EN
    // Counter is 0 in the first wait cycle; firing at TIMEOUT_CYCLES-2 puts
    // resp_valid exactly TIMEOUT_CYCLES cycles after the strobe.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 2);
    logic [15:0]          r_cnt;
    logic                 r_err;
`endif

    // Index k positions after p, wrapping modulo NUM_REQ.
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req_valid[rr_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(r_ptr, k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= PTR_W'(NUM_REQ - 1);
            r_win        <= '0;
            r_wr         <= 1'b0;
            r_ack        <= '0;
            r_resp_valid <= '0;
            r_rdata      <= '0;
            r_md_addr    <= '0;
            r_reg_addr   <= '0;
            r_wdata      <= '0;
            r_reg_wr     <= 1'b0;
            r_reg_rd     <= 1'b0;
`ifdef MDIO_ARB_TIMEOUT_EN
            r_cnt        <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_ack        <= '0;
            r_resp_valid <= '0;
            r_reg_wr     <= 1'b0;
            r_reg_rd     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Busy gating also covers a transceiver still running
                    // a transaction aborted by reset or timeout.
                    if (w_found && !mgmt_busy_fwd) begin
                        r_win      <= w_win;
                        r_ptr      <= w_win;
                        r_wr       <= req_wr[w_win];
                        r_md_addr  <= req_md_addr[int'(w_win)*5 +: 5];
                        r_reg_addr <= req_reg_addr[int'(w_win)*5 +: 5];
                        r_wdata    <= req_wdata[int'(w_win)*16 +: 16];
                        r_ack      <= onehot(w_win);
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Command bus has been stable for this whole cycle.
                    r_reg_wr <= r_wr;
                    r_reg_rd <= !r_wr;
                    r_state  <= S_ISSUE;
                end
                S_ISSUE: begin
`ifdef MDIO_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (mgmt_busy_fwd) begin
                        r_state <= S_WAIT_DONE;
                    end
`ifdef MDIO_ARB_TIMEOUT_EN
                    if (!mgmt_busy_fwd && r_cnt == TO_LAST) begin
                        r_resp_valid <= onehot(r_win);
                        r_rdata      <= 16'hFFFF;
                        r_err        <= 1'b1;
                        r_state      <= S_RESP;
                    end
                    r_cnt <= r_cnt + 16'd1;
`endif
                end
                S_WAIT_DONE: begin
                    if (!mgmt_busy_fwd) begin
                        r_resp_valid <= onehot(r_win);
                        r_rdata      <= r_wr ? 16'h0000 : phy_rd_data;
`ifdef MDIO_ARB_TIMEOUT_EN
                        r_err        <= 1'b0;
`endif
                        r_state      <= S_RESP;
                    end
`ifdef MDIO_ARB_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        r_resp_valid <= onehot(r_win);
                        r_rdata      <= 16'hFFFF;
                        r_err        <= 1'b1;
                        r_state      <= S_RESP;
                    end
                    r_cnt <= r_cnt + 16'd1;
`endif
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ack      = r_ack;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_rdata;
    assign arb_busy     = (r_state != S_IDLE);
    assign phy_md_addr  = r_md_addr;
    assign phy_reg_addr = r_reg_addr;
    assign phy_wr_data  = r_wdata;
    assign phy_reg_wr   = r_reg_wr;
    assign phy_reg_rd   = r_reg_rd;
`ifdef MDIO_ARB_TIMEOUT_EN
    assign resp_err     = r_err;
`else
    assign resp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_management_mdio_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for management_mdio_arbiter (NUM_REQ=2). The bench plays
// the transceiver by driving mgmt_busy_fwd / phy_rd_data directly.
// ---------------------------------------------------------------------------
module tb_management_mdio_arbiter;

    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_wr;
    logic [5*NR-1:0] req_md_addr;
    logic [5*NR-1:0] req_reg_addr;
    logic [16*NR-1:0] req_wdata;
    logic [NR-1:0]   req_ack;
    logic [NR-1:0]   resp_valid;
    logic [15:0]     resp_rdata;
    logic            resp_err;
    logic            arb_busy;
    logic [4:0]      phy_md_addr;
    logic [4:0]      phy_reg_addr;
    logic [15:0]     phy_wr_data;
    logic            phy_reg_wr;
    logic            phy_reg_rd;
    logic [15:0]     phy_rd_data;
    logic            mgmt_busy_fwd;

    int n_tests = 0;
    int n_fail  = 0;
    int n_strobe = 0;

    management_mdio_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_wr        (req_wr),
        .req_md_addr   (req_md_addr),
        .req_reg_addr  (req_reg_addr),
        .req_wdata     (req_wdata),
        .req_ack       (req_ack),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .arb_busy      (arb_busy),
        .phy_md_addr   (phy_md_addr),
        .phy_reg_addr  (phy_reg_addr),
        .phy_wr_data   (phy_wr_data),
        .phy_reg_wr    (phy_reg_wr),
        .phy_reg_rd    (phy_reg_rd),
        .phy_rd_data   (phy_rd_data),
        .mgmt_busy_fwd (mgmt_busy_fwd)
    );

    always #5 clk = ~clk;

    // Strobe counter; sampled before NBA update so it sees the previous cycle.
    always @(posedge clk) begin
        if (phy_reg_wr || phy_reg_rd) n_strobe <= n_strobe + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until any req_ack bit is seen, bounded to 10 cycles.
    task automatic wait_ack(output int n);
        n = 0;
        while (req_ack == '0 && n < 10) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [49:0] all_out();
        return {req_ack, resp_valid, resp_rdata, resp_err, arb_busy, phy_md_addr,
                phy_reg_addr, phy_wr_data, phy_reg_wr, phy_reg_rd};
    endfunction

    initial begin
        int          n;
        int          base;
        logic        flag;
        logic [1:0]  a;
        logic [1:0]  e;

        rst_n         = 1'b0;
        req_valid     = '0;
        req_wr        = '0;
        req_md_addr   = '0;
        req_reg_addr  = '0;
        req_wdata     = '0;
        phy_rd_data   = '0;
        mgmt_busy_fwd = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 64'(all_out()), 64'd0);
        rst_n = 1'b1;
        tick();

        // T1: single read, req0, md 0, reg 2, busy 20 cycles, data 0141
        req_valid    = 2'b01;
        req_wr       = 2'b00;
        req_md_addr  = {5'd0, 5'd0};
        req_reg_addr = {5'd0, 5'd2};
        base = n_strobe;
        tick();
        check("t1_ack", 64'(req_ack), 64'h1);
        check("t1_phy_reg_addr", 64'(phy_reg_addr), 64'd2);
        req_valid = 2'b00;
        tick();
        check("t1_rd_strobe", 64'({phy_reg_wr, phy_reg_rd}), 64'b01);
        tick();
        mgmt_busy_fwd = 1'b1;
        phy_rd_data   = 16'h0141;
        tick();
        flag = 1'b0;
        repeat (19) begin
            tick();
            if (resp_valid != '0) flag = 1'b1;
        end
        check("t1_no_early_resp", 64'(flag), 64'd0);
        mgmt_busy_fwd = 1'b0;
        tick();
        check("t1_resp_valid", 64'(resp_valid), 64'h1);
        check("t1_resp_rdata", 64'(resp_rdata), 64'h0141);
        check("t1_resp_err", 64'(resp_err), 64'd0);
        check("t1_one_strobe", 64'(n_strobe - base), 64'd1);
        phy_rd_data = 16'hDEAD;
        tick();
        check("t1_resp_pulse_end", 64'({resp_valid, arb_busy}), 64'd0);
        check("t1_rdata_hold", 64'(resp_rdata), 64'h0141);

        // T2: write req1, md 3, reg 0, wdata 8000
        req_valid    = 2'b10;
        req_wr       = 2'b10;
        req_md_addr  = {5'd3, 5'd0};
        req_reg_addr = {5'd0, 5'd0};
        req_wdata    = {16'h8000, 16'h0000};
        tick();
        check("t2_ack", 64'(req_ack), 64'h2);
        check("t2_phy_cmd", 64'({phy_md_addr, phy_reg_addr, phy_wr_data}), 64'({5'd3, 5'd0, 16'h8000}));
        req_valid = 2'b00;
        tick();
        check("t2_wr_strobe", 64'({phy_reg_wr, phy_reg_rd}), 64'b10);
        tick();
        mgmt_busy_fwd = 1'b1;
        flag = 1'b1;
        repeat (6) begin
            tick();
            if (phy_wr_data != 16'h8000 || phy_reg_wr) flag = 1'b0;
        end
        check("t2_wdata_stable", 64'(flag), 64'd1);
        phy_rd_data   = 16'hBEEF;
        mgmt_busy_fwd = 1'b0;
        tick();
        check("t2_resp_valid", 64'(resp_valid), 64'h2);
        check("t2_resp_rdata_zero", 64'(resp_rdata), 64'h0);
        tick();

        // T3: both requesters held valid, 6 transactions, strict rotation
        req_valid    = 2'b11;
        req_wr       = 2'b00;
        req_md_addr  = {5'd1, 5'd2};
        req_reg_addr = {5'd1, 5'd1};
        for (int i = 0; i < 6; i++) begin
            wait_ack(n);
            a = req_ack;
            e = (i % 2 == 1) ? 2'b10 : 2'b01;
            check($sformatf("t3_grant%0d", i), 64'(a), 64'(e));
            tick();
            tick();
            mgmt_busy_fwd = 1'b1;
            tick();
            tick();
            mgmt_busy_fwd = 1'b0;
            if (i == 5) req_valid = 2'b00;
            tick();
            check($sformatf("t3_resp%0d", i), 64'(resp_valid), 64'(e));
        end
        tick();

        // T4: requester changes fields the cycle after req_ack
        req_valid    = 2'b01;
        req_wr       = 2'b01;
        req_md_addr  = {5'd0, 5'd5};
        req_reg_addr = {5'd0, 5'd7};
        req_wdata    = {16'h0000, 16'h1234};
        wait_ack(n);
        check("t4_ack", 64'(req_ack), 64'h1);
        tick();
        req_valid    = 2'b00;
        req_wr       = 2'b00;
        req_md_addr  = {5'd31, 5'd31};
        req_reg_addr = {5'd31, 5'd31};
        req_wdata    = {16'hFFFF, 16'hFFFF};
        check("t4_wr_strobe", 64'({phy_reg_wr, phy_reg_rd}), 64'b10);
        tick();
        mgmt_busy_fwd = 1'b1;
        flag = 1'b1;
        repeat (4) begin
            tick();
            if ({phy_md_addr, phy_reg_addr, phy_wr_data} != {5'd5, 5'd7, 16'h1234}) flag = 1'b0;
        end
        check("t4_cmd_stable", 64'(flag), 64'd1);
        mgmt_busy_fwd = 1'b0;
        tick();
        check("t4_resp_valid", 64'(resp_valid), 64'h1);
        check("t4_cmd_at_resp", 64'({phy_md_addr, phy_reg_addr, phy_wr_data}), 64'({5'd5, 5'd7, 16'h1234}));
        tick();

        // T5: reset during WAIT_DONE while transceiver stays busy 10 more cycles
        req_valid    = 2'b10;
        req_wr       = 2'b00;
        req_md_addr  = {5'd9, 5'd0};
        req_reg_addr = {5'd4, 5'd0};
        wait_ack(n);
        check("t5_ack", 64'(req_ack), 64'h2);
        req_valid = 2'b00;
        tick();
        tick();
        mgmt_busy_fwd = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_reset_outputs", 64'(all_out()), 64'd0);
        tick();
        rst_n        = 1'b1;
        req_valid    = 2'b01;
        req_md_addr  = {5'd0, 5'd1};
        req_reg_addr = {5'd0, 5'd1};
        flag = 1'b0;
        repeat (9) begin
            tick();
            if (req_ack != '0 || resp_valid != '0 || phy_reg_rd || phy_reg_wr || arb_busy) flag = 1'b1;
        end
        check("t5_quiet_while_busy", 64'(flag), 64'd0);
        mgmt_busy_fwd = 1'b0;
        wait_ack(n);
        check("t5_regrant", 64'(req_ack), 64'h1);
        check("t5_regrant_latency", 64'(n), 64'd1);
        req_valid = 2'b00;
        tick();
        check("t5_strobe_after_busy", 64'({phy_reg_wr, phy_reg_rd}), 64'b01);
        tick();
        mgmt_busy_fwd = 1'b1;
        phy_rd_data   = 16'h5A5A;
        tick();
        mgmt_busy_fwd = 1'b0;
        tick();
        check("t5_resp", 64'({resp_valid, resp_rdata}), 64'({2'b01, 16'h5A5A}));
        tick();

`ifdef MDIO_ARB_TIMEOUT_EN
        // T6: busy never asserts, timeout after 100 cycles
        req_valid = 2'b01;
        req_wr    = 2'b00;
        wait_ack(n);
        check("t6_ack", 64'(req_ack), 64'h1);
        req_valid = 2'b00;
        tick();
        check("t6_strobe", 64'({phy_reg_wr, phy_reg_rd}), 64'b01);
        n = 0;
        while (resp_valid == '0 && n < 300) begin
            tick();
            n++;
        end
        check("t6_timeout_latency", 64'(n), 64'd100);
        check("t6_resp", 64'({resp_valid, resp_err, resp_rdata}), 64'({2'b01, 1'b1, 16'hFFFF}));
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
